// File: rtl/apb_rr_master.sv
// ---------------------------------------------------------------------------
// apb_rr_master
//   Round-robin APB master. Shares one APB slave between N_REQ local
//   requesters: picks a winner fairly, latches its command, runs the APB
//   SETUP/ACCESS handshake, and returns read data / error to the owner.
//   A bounded wait on pready keeps a dead slave from hanging the bus.
//
// Ports
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_req_valid        per-requester command valid            [N_REQ]
//   i_req_write        per-requester direction (1 = write)    [N_REQ]
//   i_req_addr         flattened addresses, req i at [i*ADDR_W +: ADDR_W]
//   i_req_wdata        flattened write data, req i at [i*DATA_W +: DATA_W]
//   o_req_ready        one-hot acceptance pulse, combinational, IDLE only
//   o_rsp_valid        one-hot single-cycle completion pulse to the owner
//   o_rsp_rdata        read data (0 for writes / timeouts), held until next
//   o_rsp_err          error flag (pslverr or timeout), held until next
//   o_busy             high while in SETUP or ACCESS
//   o_psel, o_penable  APB control, decoded from the state register
//   o_pwrite, o_paddr, o_pwdata  APB command, registered at acceptance
//   i_pready, i_pslverr, i_prdata  APB slave response
// ---------------------------------------------------------------------------
module apb_rr_master #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ-1:0]          i_req_write,
  input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_req_wdata,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic [N_REQ-1:0]          o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic                      o_busy,
  output logic                      o_psel,
  output logic                      o_penable,
  output logic                      o_pwrite,
  output logic [ADDR_W-1:0]         o_paddr,
  output logic [DATA_W-1:0]         o_pwdata,
  input  logic                      i_pready,
  input  logic                      i_pslverr,
  input  logic [DATA_W-1:0]         i_prdata
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_last_grant;
  logic [IDX_W-1:0]    r_owner;
  logic [CNT_W-1:0]    r_tmo_cnt;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [N_REQ-1:0]    r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic [IDX_W:0]      w_pick;
  logic                w_win_any;
  logic [IDX_W-1:0]    w_win_idx;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [N_REQ-1:0]    w_ready;

  // Round-robin search: first valid requester after 'last', wrapping.
  // Result is {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                             input logic [IDX_W-1:0] last);
    logic [IDX_W:0] res;
    int             idx;
    res = {1'b0, {IDX_W{1'b0}}};
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!res[IDX_W] && valid[IDX_W'(idx)]) begin
        res = {1'b1, IDX_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Arbitration winner for the current cycle.
  always_comb begin
    w_pick    = rr_pick(i_req_valid, r_last_grant);
    w_win_any = w_pick[IDX_W];
    w_win_idx = w_pick[IDX_W-1:0];
  end

  // Mux out the winner's command fields from the flattened request buses.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = {ADDR_W{1'b0}};
    w_sel_wdata = {DATA_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      w_sel_write = (w_win_idx == IDX_W'(i)) ? i_req_write[i] : w_sel_write;
      w_sel_addr  = (w_win_idx == IDX_W'(i)) ? i_req_addr[i*ADDR_W +: ADDR_W] : w_sel_addr;
      w_sel_wdata = (w_win_idx == IDX_W'(i)) ? i_req_wdata[i*DATA_W +: DATA_W] : w_sel_wdata;
    end
  end

  // Acceptance pulse: only offered while idle, so a request raised during a
  // transfer simply waits.
  always_comb begin
    if ((r_state == ST_IDLE) && w_win_any) begin
      w_ready = onehot(w_win_idx);
    end else begin
      w_ready = {N_REQ{1'b0}};
    end
  end

  // Transfer FSM with all command/response registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= IDX_W'(N_REQ - 1);
      r_owner      <= {IDX_W{1'b0}};
      r_tmo_cnt    <= {CNT_W{1'b0}};
      r_pwrite     <= 1'b0;
      r_paddr      <= {ADDR_W{1'b0}};
      r_pwdata     <= {DATA_W{1'b0}};
      r_rsp_valid  <= {N_REQ{1'b0}};
      r_rsp_rdata  <= {DATA_W{1'b0}};
      r_rsp_err    <= 1'b0;
    end else begin
      r_rsp_valid <= {N_REQ{1'b0}};
      case (r_state)
        ST_IDLE: begin
          if (w_win_any) begin
            r_pwrite     <= w_sel_write;
            r_paddr      <= w_sel_addr;
            r_pwdata     <= w_sel_wdata;
            r_owner      <= w_win_idx;
            r_last_grant <= w_win_idx;
            r_state      <= ST_SETUP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          r_tmo_cnt <= {CNT_W{1'b0}};
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready is only looked at here, so a late/stale pready seen in
          // IDLE or SETUP can never complete the wrong transfer.
          if (i_pready) begin
            r_rsp_valid <= onehot(r_owner);
            r_rsp_rdata <= r_pwrite ? {DATA_W{1'b0}} : i_prdata;
            r_rsp_err   <= i_pslverr;
            r_state     <= ST_IDLE;
          end else if (r_tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_rsp_valid <= onehot(r_owner);
            r_rsp_rdata <= {DATA_W{1'b0}};
            r_rsp_err   <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1'b1);
            r_state   <= ST_ACCESS;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = w_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_busy      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign o_psel      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign o_penable   = (r_state == ST_ACCESS);
  assign o_pwrite    = r_pwrite;
  assign o_paddr     = r_paddr;
  assign o_pwdata    = r_pwdata;

endmodule
